// File: rtl/contador_de_deteccoes_if.sv
// Bundle of the detection-counter signals: the master drives z/habilita,
// the slave (the counter) drives the window results.
interface contador_de_deteccoes_if #(
    parameter int unsigned LARGURA = 8
) ();
    logic               z;
    logic               habilita;
    logic [LARGURA-1:0] contagem;
    logic               pronto;
    logic               alarme;
    logic               ocupado;

    modport master (
        output z,
        output habilita,
        input  contagem,
        input  pronto,
        input  alarme,
        input  ocupado
    );

    modport slave (
        input  z,
        input  habilita,
        output contagem,
        output pronto,
        output alarme,
        output ocupado
    );
endinterface

// File: rtl/contador_de_deteccoes.sv
// Counts rising edges of z over fixed windows of JANELA cycles, reporting
// the count, a completion pulse and a threshold alarm per window.
module contador_de_deteccoes #(
    parameter int unsigned LARGURA = 8,
    parameter int unsigned JANELA  = 16,
    parameter int unsigned LIMIAR  = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    contador_de_deteccoes_if.slave bus
);

    localparam int unsigned CicloW = $clog2(JANELA);
    localparam logic [CicloW-1:0]  Ultimo = CicloW'(JANELA - 1);
    localparam logic [LARGURA-1:0] Limiar = LARGURA'(LIMIAR);

    typedef enum logic [1:0] {
        StOcioso,
        StContando,
        StFim
    } estado_e;

    estado_e            estado_q;
    logic               z_ant_q;
    logic [CicloW-1:0]  ciclos_q;
    logic [LARGURA-1:0] deteccoes_q;
    logic [LARGURA-1:0] contagem_q;
    logic               pronto_q;
    logic               alarme_q;
    logic               ocupado_q;

    logic               deteccao;
    logic [LARGURA-1:0] deteccoes_prox;

    // Saturating count including the current cycle's detection.
    always_comb begin
        deteccao       = bus.z & ~z_ant_q;
        deteccoes_prox = deteccoes_q;
        if (deteccao && (deteccoes_q != '1)) begin
            deteccoes_prox = deteccoes_q + LARGURA'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q    <= StOcioso;
            z_ant_q     <= 1'b0;
            ciclos_q    <= '0;
            deteccoes_q <= '0;
            contagem_q  <= '0;
            pronto_q    <= 1'b0;
            alarme_q    <= 1'b0;
            ocupado_q   <= 1'b0;
        end else begin
            z_ant_q  <= bus.z;
            pronto_q <= 1'b0;
            unique case (estado_q)
                StOcioso: begin
                    if (bus.habilita) begin
                        estado_q    <= StContando;
                        ciclos_q    <= '0;
                        deteccoes_q <= '0;
                        ocupado_q   <= 1'b1;
                    end else begin
                        ocupado_q <= 1'b0;
                    end
                end
                StContando: begin
                    // Abort wins over the window end.
                    if (!bus.habilita) begin
                        estado_q  <= StOcioso;
                        ocupado_q <= 1'b0;
                    end else if (ciclos_q == Ultimo) begin
                        estado_q   <= StFim;
                        contagem_q <= deteccoes_prox;
                        alarme_q   <= (deteccoes_prox >= Limiar);
                        pronto_q   <= 1'b1;
                        ocupado_q  <= 1'b1;
                    end else begin
                        ciclos_q    <= ciclos_q + CicloW'(1);
                        deteccoes_q <= deteccoes_prox;
                        ocupado_q   <= 1'b1;
                    end
                end
                StFim: begin
                    if (bus.habilita) begin
                        estado_q    <= StContando;
                        ciclos_q    <= '0;
                        deteccoes_q <= '0;
                        ocupado_q   <= 1'b1;
                    end else begin
                        estado_q  <= StOcioso;
                        ocupado_q <= 1'b0;
                    end
                end
                default: begin
                    estado_q  <= StOcioso;
                    ocupado_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.contagem = contagem_q;
    assign bus.pronto   = pronto_q;
    assign bus.alarme   = alarme_q;
    assign bus.ocupado  = ocupado_q;

endmodule

// File: tb/tb_contador_de_deteccoes.sv
// Directed bench for contador_de_deteccoes: a default instance and a
// LARGURA=2 instance for saturation.
module tb_contador_de_deteccoes;

    logic clock;
    logic reset;

    int n_assert = 0;
    int n_falhas = 0;

    contador_de_deteccoes_if #(.LARGURA(8)) bus_a ();
    contador_de_deteccoes_if #(.LARGURA(2)) bus_b ();

    contador_de_deteccoes #(
        .LARGURA(8),
        .JANELA (16),
        .LIMIAR (3)
    ) dut_a (
        .clock(clock),
        .reset(reset),
        .bus  (bus_a.slave)
    );

    contador_de_deteccoes #(
        .LARGURA(2),
        .JANELA (16),
        .LIMIAR (3)
    ) dut_b (
        .clock(clock),
        .reset(reset),
        .bus  (bus_b.slave)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic passo(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_assert++;
        assert (obs === esp)
        else begin
            n_falhas++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, esp);
        end
    endtask

    int gap;
    int n_pronto;

    initial begin
        reset          = 1'b1;
        bus_a.z        = 1'b0;
        bus_a.habilita = 1'b0;
        bus_b.z        = 1'b0;
        bus_b.habilita = 1'b0;
        #2 reset = 1'b0;
        #4;
        verifica("rst_contagem", 32'(bus_a.contagem), 0);
        verifica("rst_pronto", 32'(bus_a.pronto), 0);
        verifica("rst_alarme", 32'(bus_a.alarme), 0);
        verifica("rst_ocupado", 32'(bus_a.ocupado), 0);
        verifica("rst_b_contagem", 32'(bus_b.contagem), 0);
        passo(2);
        reset = 1'b1;
        passo(3);
        verifica("ocioso_sem_habilita", 32'(bus_a.ocupado), 0);

        // Window 1: three isolated pulses.
        bus_a.habilita = 1'b1;
        passo(1);
        verifica("entrada_ocupado", 32'(bus_a.ocupado), 1);
        verifica("entrada_pronto", 32'(bus_a.pronto), 0);
        for (int i = 1; i <= 16; i++) begin
            bus_a.z = (i == 2 || i == 5 || i == 9);
            passo(1);
            if (i == 15) verifica("pronto_cedo", 32'(bus_a.pronto), 0);
        end
        verifica("j1_pronto", 32'(bus_a.pronto), 1);
        verifica("j1_contagem", 32'(bus_a.contagem), 3);
        verifica("j1_alarme", 32'(bus_a.alarme), 1);
        verifica("j1_ocupado", 32'(bus_a.ocupado), 1);

        // Pulse during FIM must not count; measure pronto period.
        bus_a.z = 1'b1;
        passo(1);
        bus_a.z = 1'b0;
        verifica("fim_pronto_baixa", 32'(bus_a.pronto), 0);
        gap = 1;
        while (!bus_a.pronto && gap < 40) begin
            passo(1);
            gap++;
        end
        verifica("periodo_pronto", 32'(gap), 17);
        verifica("j2_contagem", 32'(bus_a.contagem), 0);
        verifica("j2_alarme", 32'(bus_a.alarme), 0);

        // Window 3: z held high for 10 cycles.
        for (int i = 0; i <= 16; i++) begin
            bus_a.z = (i >= 3 && i <= 12);
            passo(1);
        end
        verifica("j3_pronto", 32'(bus_a.pronto), 1);
        verifica("j3_contagem", 32'(bus_a.contagem), 1);
        verifica("j3_alarme", 32'(bus_a.alarme), 0);

        // Window 4: three pulses again.
        for (int i = 0; i <= 16; i++) begin
            bus_a.z = (i == 2 || i == 5 || i == 9);
            passo(1);
        end
        verifica("j4_contagem", 32'(bus_a.contagem), 3);
        verifica("j4_alarme", 32'(bus_a.alarme), 1);

        // Window 5: two pulses then abort at counting cycle 8.
        for (int i = 0; i <= 7; i++) begin
            bus_a.z = (i == 2 || i == 4);
            passo(1);
        end
        bus_a.habilita = 1'b0;
        passo(1);
        verifica("aborto_ocupado", 32'(bus_a.ocupado), 0);
        verifica("aborto_contagem", 32'(bus_a.contagem), 3);
        verifica("aborto_alarme", 32'(bus_a.alarme), 1);
        n_pronto = 0;
        repeat (20) begin
            passo(1);
            n_pronto += int'(bus_a.pronto);
        end
        verifica("aborto_sem_pronto", 32'(n_pronto), 0);

        // Reset in the 5th counting cycle after 2 detections.
        bus_a.habilita = 1'b1;
        passo(1);
        for (int i = 1; i <= 4; i++) begin
            bus_a.z = (i == 1 || i == 3);
            passo(1);
        end
        bus_a.z = 1'b0;
        reset   = 1'b0;
        #1;
        verifica("rst_meio_contagem", 32'(bus_a.contagem), 0);
        verifica("rst_meio_alarme", 32'(bus_a.alarme), 0);
        verifica("rst_meio_ocupado", 32'(bus_a.ocupado), 0);
        verifica("rst_meio_pronto", 32'(bus_a.pronto), 0);
        passo(1);
        bus_a.habilita = 1'b0;
        reset          = 1'b1;
        passo(3);
        verifica("pos_rst_ocioso", 32'(bus_a.ocupado), 0);
        bus_a.habilita = 1'b1;
        passo(1);
        for (int i = 1; i <= 16; i++) begin
            bus_a.z = (i == 6);
            passo(1);
        end
        verifica("pos_rst_pronto", 32'(bus_a.pronto), 1);
        verifica("pos_rst_contagem", 32'(bus_a.contagem), 1);
        verifica("pos_rst_alarme", 32'(bus_a.alarme), 0);
        bus_a.habilita = 1'b0;
        bus_a.z        = 1'b0;
        passo(2);

        // Saturation: 8 edges into a 2-bit counter.
        bus_b.habilita = 1'b1;
        passo(1);
        for (int i = 1; i <= 16; i++) begin
            bus_b.z = (i % 2 == 1);
            passo(1);
        end
        verifica("sat_pronto", 32'(bus_b.pronto), 1);
        verifica("sat_contagem", 32'(bus_b.contagem), 3);
        verifica("sat_alarme", 32'(bus_b.alarme), 1);
        bus_b.habilita = 1'b0;
        bus_b.z        = 1'b0;
        passo(2);
        verifica("sat_ocioso", 32'(bus_b.ocupado), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_falhas);
        $finish;
    end

endmodule

// File: doc/contador_de_deteccoes.md
CONTADOR_DE_DETECCOES -- requirements
Module: contador_de_deteccoes

Parameters
REQ-001 The block SHALL have parameter LARGURA, default 8, giving the width of the detection count.
REQ-002 The block SHALL have parameter JANELA, default 16, giving the number of counting cycles per window (JANELA >= 2).
REQ-003 The block SHALL have parameter LIMIAR, default 3, giving the alarm threshold (0 <= LIMIAR <= 2^LARGURA-1).

Interface
REQ-004 clock  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-low.
REQ-006 z  input  1  detection output of the upstream sequence-detector FSM, same clock domain.
REQ-007 habilita  input  1  run enable; 1 starts and continues windows, 0 stops or aborts them.
REQ-008 contagem  output  LARGURA  detection count of the last completed window.
REQ-009 pronto  output  1  one-cycle pulse marking a completed window.
REQ-010 alarme  output  1  1 when the last completed window's count >= LIMIAR.
REQ-011 ocupado  output  1  1 whenever the FSM is not in OCIOSO.

Function
REQ-012 The FSM SHALL have three states: OCIOSO, CONTANDO, FIM.
REQ-013 A register z_ant SHALL capture z every cycle, in every state.
REQ-014 A detection SHALL be one rising edge of z: z=1 and z_ant=0 in the same cycle.
REQ-015 OCIOSO: if habilita=1 -> CONTANDO, with the cycle counter and the detection counter cleared to 0; else stay.
REQ-016 CONTANDO: each cycle, cycle counter +1; detection counter +1 on a detection.
REQ-017 CONTANDO: after exactly JANELA cycles (the cycle counter = JANELA-1) -> FIM; a detection in that last cycle is counted.
REQ-018 CONTANDO: habilita=0 in any cycle -> OCIOSO (abort); no pronto; contagem and alarme are unchanged.
REQ-019 Abort SHALL take priority over the window end when both occur in the same cycle.
REQ-020 On the edge entering FIM: contagem <= detection count; alarme <= (count >= LIMIAR).
REQ-021 pronto SHALL be 1 exactly during the single cycle spent in FIM, otherwise 0.
REQ-022 FIM: if habilita=1 -> CONTANDO (new window, counters cleared); else -> OCIOSO.
REQ-023 A detection occurring during FIM or OCIOSO SHALL NOT be counted in any window.
REQ-024 The detection counter SHALL saturate at 2^LARGURA-1, with no wrap-around.
REQ-025 contagem and alarme SHALL hold their values between FIM cycles.
REQ-026 z held high across many cycles SHALL count once.
REQ-027 z already high on entry to CONTANDO (z_ant=1) SHALL NOT count until z falls and rises again.
REQ-028 Latency: habilita=1 sampled in OCIOSO at edge k gives pronto high in cycle k+JANELA+1.
REQ-029 With habilita held at 1, the pronto period SHALL be JANELA+1 cycles.

Reset
REQ-030 reset=0 SHALL immediately force state OCIOSO; contagem=0; pronto=0; alarme=0; ocupado=0; z_ant=0; both internal counters=0.
REQ-031 Reset asserted mid-window SHALL discard the partial count, with no pronto pulse.
REQ-032 After reset is released, the block SHALL start a window only when habilita=1 is sampled in OCIOSO.

Verification (defaults unless stated)
REQ-033 Reset in the 5th CONTANDO cycle with 2 detections -> all outputs 0 at once; no pronto; the next window starts from 0.
REQ-034 habilita=1 held; 3 isolated one-cycle z pulses inside the window -> pronto in cycle k+17; contagem=3; alarme=1.
REQ-035 z held high for 10 cycles inside the window -> contagem=1; alarme=0.
REQ-036 Window completes with contagem=3; next window: 2 pulses, then habilita=0 at cycle 8 -> OCIOSO; no pronto; contagem=3 and alarme=1 unchanged; ocupado=0.
REQ-037 LARGURA=2; z toggling every cycle for a full window (8 edges) -> contagem=3 (saturated); alarme=1.
REQ-038 habilita held; z pulse in the FIM cycle -> not counted in either window; pronto pulses 17 cycles apart.
